// File: rtl/align_shift_if.sv
// Handshake bundle for align_shift_pipe. The unit connects through the slave modport.
// When ALIGN_LEFT_EN is defined, the bundle also carries the in_left direction bit.
interface align_shift_if #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
);
    // Valid/ready: a transfer happens on a rising clk edge where valid && ready.
    // A producer holds its payload stable until that transfer. Ready never
    // looks at valid on the same side of the interface.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
`ifdef ALIGN_LEFT_EN
    logic               in_left;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_guard;
    logic               out_round;
    logic               out_sticky;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    modport master (
`ifdef ALIGN_LEFT_EN
        output in_left,
`endif
        output in_valid, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_guard, out_round,
        input  out_sticky, out_tag, out_zero
    );

    modport slave (
`ifdef ALIGN_LEFT_EN
        input  in_left,
`endif
        input  in_valid, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_guard, out_round,
        output out_sticky, out_tag, out_zero
    );
endinterface

// File: rtl/align_shift_pipe.sv
// Two-stage right-shift alignment with guard/round/sticky generation for the FP adder.
// Define ALIGN_LEFT_EN to add a per-operation left-shift (normalisation) mode.
module align_shift_pipe #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 8,
    parameter int SPLIT   = 3,
    parameter int TAG_W   = 4
) (
    input logic        clk,
    input logic        rst_n,
    align_shift_if.slave bus
);
    localparam int EXT_W = WIDTH + 2;
    localparam logic [SHAMT_W-1:0] LO_MASK = SHAMT_W'((1 << SPLIT) - 1);

    logic               s1_valid_q, s1_valid_d;
    logic [EXT_W-1:0]   s1_vec_q, s1_vec_d;
    logic               s1_sticky_q, s1_sticky_d;
    logic [SPLIT-1:0]   s1_lo_q, s1_lo_d;
    logic               s1_left_q, s1_left_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_guard_q, out_guard_d;
    logic               out_round_q, out_round_d;
    logic               out_sticky_q, out_sticky_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_zero_q, out_zero_d;

    logic               s2_adv;
    logic               s1_adv;
    logic               in_left;
    logic               in_sat;
    logic [SHAMT_W-1:0] shamt_hi;
    logic [EXT_W-1:0]   ext_in;
    logic [EXT_W-1:0]   lost1;
    logic [EXT_W-1:0]   s2_vec;
    logic [EXT_W-1:0]   lost2;
    logic               s2_sticky;

`ifdef ALIGN_LEFT_EN
    assign in_left = bus.in_left;
`else
    assign in_left = 1'b0;
`endif

    // Advance conditions depend only on registered valids and out_ready,
    // so in_ready has no path from in_valid.
    always_comb begin
        s2_adv = !out_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign bus.in_ready = s1_adv;

    // Stage 1: coarse shift by the high shift bits, saturation decided here.
    always_comb begin
        shamt_hi = bus.in_shamt & ~LO_MASK;
        ext_in   = {bus.in_data, 2'b00};
        in_sat   = 32'(bus.in_shamt) >= 32'(EXT_W);
        lost1    = ext_in & ~({EXT_W{1'b1}} << shamt_hi);

        s1_valid_d  = s1_valid_q;
        s1_vec_d    = s1_vec_q;
        s1_sticky_d = s1_sticky_q;
        s1_lo_d     = s1_lo_q;
        s1_left_d   = s1_left_q;
        s1_tag_d    = s1_tag_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (s1_adv && bus.in_valid) begin
            s1_tag_d  = bus.in_tag;
            s1_left_d = in_left;
            s1_lo_d   = bus.in_shamt[SPLIT-1:0];
            if (in_left) begin
                // Overflowing bits simply drop off the top; no rounding info.
                s1_vec_d    = ext_in << shamt_hi;
                s1_sticky_d = 1'b0;
            end else if (in_sat) begin
                // Everything is shifted out; zero the fine shift so stage 2 is a no-op.
                s1_vec_d    = '0;
                s1_sticky_d = |bus.in_data;
                s1_lo_d     = '0;
            end else begin
                s1_vec_d    = ext_in >> shamt_hi;
                s1_sticky_d = |lost1;
            end
        end
    end

    // Stage 2: fine shift by the low bits, fold newly lost bits into sticky.
    always_comb begin
        s2_vec    = s1_left_q ? (s1_vec_q << s1_lo_q) : (s1_vec_q >> s1_lo_q);
        lost2     = s1_left_q ? '0 : (s1_vec_q & ~({EXT_W{1'b1}} << s1_lo_q));
        s2_sticky = s1_sticky_q | (|lost2);

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_guard_d  = out_guard_q;
        out_round_d  = out_round_q;
        out_sticky_d = out_sticky_q;
        out_tag_d    = out_tag_q;
        out_zero_d   = out_zero_q;

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            out_data_d   = s2_vec[EXT_W-1:2];
            out_guard_d  = s2_vec[1];
            out_round_d  = s2_vec[0];
            out_sticky_d = s2_sticky;
            out_tag_d    = s1_tag_q;
            out_zero_d   = !((|s2_vec) || s2_sticky);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_vec_q     <= '0;
            s1_sticky_q  <= 1'b0;
            s1_lo_q      <= '0;
            s1_left_q    <= 1'b0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_guard_q  <= 1'b0;
            out_round_q  <= 1'b0;
            out_sticky_q <= 1'b0;
            out_tag_q    <= '0;
            out_zero_q   <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_vec_q     <= s1_vec_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_lo_q      <= s1_lo_d;
            s1_left_q    <= s1_left_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_guard_q  <= out_guard_d;
            out_round_q  <= out_round_d;
            out_sticky_q <= out_sticky_d;
            out_tag_q    <= out_tag_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_guard  = out_guard_q;
    assign bus.out_round  = out_round_q;
    assign bus.out_sticky = out_sticky_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_zero   = out_zero_q;

endmodule

// File: tb/tb_align_shift_pipe.sv
// Self-checking bench for align_shift_pipe: directed cases, backpressure, reset, random sweep.
// Covers the ALIGN_LEFT_EN left-shift mode when that macro is defined.
module tb_align_shift_pipe;
    localparam int WIDTH   = 24;
    localparam int SHAMT_W = 8;
    localparam int SPLIT   = 3;
    localparam int TAG_W   = 4;
    localparam int RES_W   = WIDTH + 3 + TAG_W;
    localparam int N_OPS   = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [RES_W-1:0] exp_q[$];

    align_shift_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) bus ();

    align_shift_pipe #(
        .WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .SPLIT(SPLIT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Bit-by-bit walk over ext = {data, 00}: bits moved below position 0 feed sticky.
    function automatic logic [RES_W-1:0] model(input logic [WIDTH-1:0] d,
                                                input logic [SHAMT_W-1:0] s,
                                                input logic [TAG_W-1:0] t,
                                                input logic lft);
        logic [WIDTH+1:0] ext;
        logic [WIDTH+1:0] r;
        logic st;
        int sh;
        ext = {d, 2'b00};
        r   = '0;
        st  = 1'b0;
        sh  = int'(s);
        for (int j = 0; j < WIDTH + 2; j++) begin
            if (lft) begin
                if (j + sh < WIDTH + 2) r[j + sh] = ext[j];
            end else if (j < sh) begin
                st = st | ext[j];
            end else begin
                r[j - sh] = ext[j];
            end
        end
        return {r, st, t};
    endfunction

    function automatic logic [RES_W-1:0] pack_out();
        return {bus.out_data, bus.out_guard, bus.out_round, bus.out_sticky, bus.out_tag};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [RES_W-1:0] held;
    logic prev_stall = 1'b0;
    logic mon_left;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", bus.out_valid, 1);
                check("stall_data_hold", pack_out(), held);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_without_input: got result 0x%0h, expected none", pack_out());
                end else begin
                    check("sb_result", pack_out(), exp_q[0]);
                    check("sb_zero", bus.out_zero, exp_q[0][RES_W-1:TAG_W] == '0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = pack_out();
`ifdef ALIGN_LEFT_EN
            mon_left = bus.in_left;
`else
            mon_left = 1'b0;
`endif
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_data, bus.in_shamt, bus.in_tag, mon_left));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                          input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_tag   = t;
    endtask

    task automatic rand_op();
        logic [WIDTH-1:0] d;
        case ($urandom_range(0, 3))
            0: d = WIDTH'($urandom);
            1: d = '0;
            2: d = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            default: d = WIDTH'($urandom_range(0, 255));
        endcase
        set_op(d,
               $urandom_range(0, 1) == 1 ? SHAMT_W'($urandom_range(0, 31))
                                         : SHAMT_W'($urandom_range(0, 255)),
               TAG_W'($urandom));
        bus.in_valid = ($urandom_range(0, 9) < 8);
`ifdef ALIGN_LEFT_EN
        bus.in_left = ($urandom_range(0, 3) == 0);
`endif
    endtask

    // One isolated op with out_ready high; checks the two-cycle latency and literal results.
    task automatic run_one(input string name, input logic [WIDTH-1:0] d,
                           input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t,
                           input logic [WIDTH-1:0] e_data, input logic e_g, input logic e_r,
                           input logic e_s, input logic e_zero);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        set_op(d, s, t);
        @(negedge clk);
        check({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1_idle"}, bus.out_valid, 0);
        @(negedge clk);
        check({name, "_lat2_valid"}, bus.out_valid, 1);
        check({name, "_data"}, bus.out_data, e_data);
        check({name, "_grs"}, {bus.out_guard, bus.out_round, bus.out_sticky}, {e_g, e_r, e_s});
        check({name, "_tag"}, bus.out_tag, t);
        check({name, "_zero"}, bus.out_zero, e_zero);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sent;
        int cyc;
        int cnt;
        logic take;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
`ifdef ALIGN_LEFT_EN
        bus.in_left   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_zero", bus.out_zero, 1);
        check("reset_out_data", bus.out_data, 0);

        // Hand-computed values pin the model itself.
        check("model_t1", model(24'h800001, 8'd1, 4'h0, 1'b0), {24'h400000, 3'b100, 4'h0});
        check("model_t2a", model(24'h800007, 8'd3, 4'h0, 1'b0), {24'h100000, 3'b111, 4'h0});
        check("model_t2b", model(24'h800000, 8'd24, 4'h0, 1'b0), {24'h000000, 3'b100, 4'h0});
        check("model_t3a", model(24'h000001, 8'd26, 4'h0, 1'b0), {24'h000000, 3'b001, 4'h0});
        check("model_t3b", model(24'h000000, 8'd255, 4'h0, 1'b0), {24'h000000, 3'b000, 4'h0});
        check("model_pass", model(24'hABCDEF, 8'd0, 4'h0, 1'b0), {24'hABCDEF, 3'b000, 4'h0});

        run_one("t1",     24'h800001, 8'd1,   4'h5, 24'h400000, 1, 0, 0, 0);
        run_one("t2a",    24'h800007, 8'd3,   4'h6, 24'h100000, 1, 1, 1, 0);
        run_one("t2b",    24'h800000, 8'd24,  4'h7, 24'h000000, 1, 0, 0, 0);
        run_one("t3a",    24'h000001, 8'd26,  4'h8, 24'h000000, 0, 0, 1, 0);
        run_one("t3b",    24'h000000, 8'd255, 4'h9, 24'h000000, 0, 0, 0, 1);
        run_one("t3c",    24'hFFFFFF, 8'd200, 4'hA, 24'h000000, 0, 0, 1, 0);
        run_one("pass0",  24'hABCDEF, 8'd0,   4'hB, 24'hABCDEF, 0, 0, 0, 0);
        run_one("sat25",  24'h800000, 8'd25,  4'hC, 24'h000000, 0, 1, 0, 0);

        // Backpressure: two ops fill the pipe, third waits, then all drain in order.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_op(24'hABCDEF, SHAMT_W'(k), TAG_W'(k + 1));
            @(negedge clk);
            check("bp_accept", bus.in_ready, 1);
            @(posedge clk); #1;
        end
        set_op(24'hABCDEF, 8'd2, 4'h3);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_res0_valid", bus.out_valid, 1);
        check("bp_res0_data", bus.out_data, 24'hABCDEF);
        check("bp_in_ready_back", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_res1_valid", bus.out_valid, 1);
        check("bp_res1_data", bus.out_data, 24'h55E6F7);
        @(negedge clk);
        check("bp_res2_valid", bus.out_valid, 1);
        check("bp_res2_data", bus.out_data, 24'h2AF37B);
        @(negedge clk);
        check("bp_drained", bus.out_valid, 0);

        // Reset with both stages full.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_op(24'h123456, SHAMT_W'(k + 4), TAG_W'(k + 0));
            @(negedge clk);
            check("rst_fill_accept", bus.in_ready, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("rst_pre_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_zero", bus.out_zero, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 1);
        end

`ifdef ALIGN_LEFT_EN
        bus.in_left = 1'b1;
        run_one("left4",  24'h000003, 8'd4,  4'h1, 24'h000030, 0, 0, 0, 0);
        run_one("left24", 24'hFFFFFF, 8'd24, 4'h2, 24'h000000, 0, 0, 0, 1);
        run_one("left23", 24'h000003, 8'd23, 4'h3, 24'h800000, 0, 0, 0, 0);
        bus.in_left = 1'b0;
`endif

        // Random sweep with random in_valid / out_ready; the scoreboard checks every output.
        sent = 0;
        cyc  = 0;
        @(posedge clk); #1;
        rand_op();
        while (sent < N_OPS && cyc < 40000) begin
            @(negedge clk);
            take = bus.in_valid && bus.in_ready;
            if (take) sent++;
            @(posedge clk); #1;
            cyc++;
            if (sent >= N_OPS) bus.in_valid = 1'b0;
            else if (!bus.in_valid || take) rand_op();
            bus.out_ready = ($urandom_range(0, 9) < 8);
        end
        check("sweep_ops_sent", sent, N_OPS);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        @(negedge clk);
        check("sweep_drained", exp_q.size(), 0);
        check("sweep_idle", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
